// File: rtl/vdp_package.sv
// Raster geometry shared by the VDP screen counter and the timing-control stages.
// Defaults describe the 42.95454 MHz NTSC/PAL raster; stages may override via parameters.
package vdp_package;

    localparam int VDP_H_TOTAL      = 2736;
    localparam int VDP_H_SYNC       = 202;
    localparam int VDP_H_LEFT       = 128;
    localparam int VDP_V_SYNC       = 3;
    localparam int VDP_V_TOP_60     = 26;
    localparam int VDP_V_TOP_50     = 53;
    localparam int VDP_ACTIVE_W     = 2048;
    localparam int VDP_ACTIVE_H_192 = 192;
    localparam int VDP_ACTIVE_H_212 = 212;
    localparam int VDP_V_TOTAL_60   = 262;
    localparam int VDP_V_TOTAL_50   = 313;

    localparam int H_CNT_W = 12;
    localparam int V_CNT_W = 9;
    localparam int POS_X_W = 13;
    localparam int POS_Y_W = 10;

    // Frame-wide settings captured once at the first clock of each frame.
    typedef struct packed {
        logic       mode_50hz;
        logic       lines_212;
        logic [3:0] adjust_v;
    } frame_cfg_t;

    function automatic logic [POS_Y_W-1:0] sext_adj_v(input logic [3:0] adj);
        return {{(POS_Y_W-4){adj[3]}}, adj};
    endfunction

endpackage

// File: rtl/vdp_screen_counter.sv
// Free-running raster counter producing the signed screen position, active window,
// sync, field and interrupt strobes for all downstream VDP timing stages.
module vdp_screen_counter
    import vdp_package::*;
#(
    parameter int H_TOTAL      = VDP_H_TOTAL,
    parameter int H_SYNC       = VDP_H_SYNC,
    parameter int H_LEFT       = VDP_H_LEFT,
    parameter int V_SYNC       = VDP_V_SYNC,
    parameter int V_TOP_60     = VDP_V_TOP_60,
    parameter int V_TOP_50     = VDP_V_TOP_50,
    parameter int ACTIVE_W     = VDP_ACTIVE_W,
    parameter int ACTIVE_H_192 = VDP_ACTIVE_H_192,
    parameter int ACTIVE_H_212 = VDP_ACTIVE_H_212,
    parameter int V_TOTAL_60   = VDP_V_TOTAL_60,
    parameter int V_TOTAL_50   = VDP_V_TOTAL_50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reg_50hz_mode,
    input  logic               reg_interlace_mode,
    input  logic               reg_212lines_mode,
    input  logic [3:0]         reg_adjust_h,
    input  logic [3:0]         reg_adjust_v,
    input  logic [7:0]         reg_interrupt_line,
    output logic signed [12:0] screen_pos_x,
    output logic signed [9:0]  screen_pos_y,
    output logic               screen_active,
    output logic               h_sync,
    output logic               v_sync,
    output logic               field,
    output logic               intr_line,
    output logic               intr_frame
);

    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               field_q, field_d;
    logic [3:0]         adj_h_q, adj_h_d;
    frame_cfg_t         cfg_q, cfg_d;

    logic               line_start, frame_start, h_wrap;
    logic [V_CNT_W-1:0] v_last;

    // At the first clock of a line/frame the live register value is used directly,
    // so the whole line (or frame) sees one consistent setting with no torn first pixel.
    always_comb begin
        line_start  = (h_cnt_q == '0);
        frame_start = line_start && (v_cnt_q == '0);
        adj_h_d     = line_start  ? reg_adjust_h : adj_h_q;
        cfg_d       = frame_start ? {reg_50hz_mode, reg_212lines_mode, reg_adjust_v} : cfg_q;

        if (cfg_d.mode_50hz)
            v_last = V_CNT_W'(V_TOTAL_50 - 1);
        else if (reg_interlace_mode && field_q)
            v_last = V_CNT_W'(V_TOTAL_60);
        else
            v_last = V_CNT_W'(V_TOTAL_60 - 1);

        h_wrap  = (h_cnt_q == H_CNT_W'(H_TOTAL - 1));
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        field_d = field_q;
        if (h_wrap) begin
            if (v_cnt_q == v_last) begin
                v_cnt_d = '0;
                field_d = reg_interlace_mode ? ~field_q : 1'b0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            adj_h_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            adj_h_q <= adj_h_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_cnt_q <= '0;
            field_q <= 1'b0;
            cfg_q   <= '0;
        end else begin
            v_cnt_q <= v_cnt_d;
            field_q <= field_d;
            cfg_q   <= cfg_d;
        end
    end

    logic [POS_X_W-1:0] pos_x_d, pos_x_q, adj_h_px;
    logic [POS_Y_W-1:0] pos_y_d, pos_y_q, v_top, height;
    logic               active_d, active_q, h_sync_d, h_sync_q, v_sync_d, v_sync_q;
    logic               field_out_q, x_at_end, intr_line_d, intr_line_q, intr_frame_d, intr_frame_q;

    // Position arithmetic is done on raw bit vectors; the two's complement wrap is intended.
    always_comb begin
        adj_h_px = {{(POS_X_W-7){adj_h_d[3]}}, adj_h_d, 3'b000};
        v_top    = cfg_d.mode_50hz ? POS_Y_W'(V_TOP_50) : POS_Y_W'(V_TOP_60);
        height   = cfg_d.lines_212 ? POS_Y_W'(ACTIVE_H_212) : POS_Y_W'(ACTIVE_H_192);
        pos_x_d  = {1'b0, h_cnt_q} - POS_X_W'(H_LEFT) - adj_h_px;
        pos_y_d  = {1'b0, v_cnt_q} - v_top - sext_adj_v(cfg_d.adjust_v);

        active_d = !pos_x_d[POS_X_W-1] && (pos_x_d < POS_X_W'(ACTIVE_W)) &&
                   !pos_y_d[POS_Y_W-1] && (pos_y_d < height);
        x_at_end     = (pos_x_d == POS_X_W'(ACTIVE_W));
        intr_line_d  = x_at_end && (pos_y_d == {2'b00, reg_interrupt_line});
        intr_frame_d = x_at_end && (pos_y_d == height - 1'b1);
        h_sync_d     = (h_cnt_q < H_CNT_W'(H_SYNC));
        v_sync_d     = (v_cnt_q < V_CNT_W'(V_SYNC));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q      <= POS_X_W'(-H_LEFT);
            pos_y_q      <= POS_Y_W'(-V_TOP_60);
            active_q     <= 1'b0;
            h_sync_q     <= 1'b0;
            v_sync_q     <= 1'b0;
            field_out_q  <= 1'b0;
            intr_line_q  <= 1'b0;
            intr_frame_q <= 1'b0;
        end else begin
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            active_q     <= active_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            field_out_q  <= field_q;
            intr_line_q  <= intr_line_d;
            intr_frame_q <= intr_frame_d;
        end
    end

    assign screen_pos_x  = pos_x_q;
    assign screen_pos_y  = pos_y_q;
    assign screen_active = active_q;
    assign h_sync        = h_sync_q;
    assign v_sync        = v_sync_q;
    assign field         = field_out_q;
    assign intr_line     = intr_line_q;
    assign intr_frame    = intr_frame_q;

endmodule
